// File: rtl/bank_rotator_ctrl.sv
// N-bank stereo frame-history controller: two banks are written per frame, and the
// previous frame's R/L plus the L from two frames back are readable.

module bram_sd #(
  parameter int DW    = 148,
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

module bank_rotator_ctrl #(
  parameter int DATA_W    = 148,
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter int NUM_BANKS = 5,
  parameter int OUT_REG   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fsync,
  input  logic              WRE,
  input  logic [ADDR_W-1:0] W_R_addr,
  input  logic [DATA_W-1:0] W_R_data,
  input  logic              WLE,
  input  logic [ADDR_W-1:0] W_L_addr,
  input  logic [DATA_W-1:0] W_L_data,
  input  logic              R_en,
  input  logic [ADDR_W-1:0] R_R_addr,
  input  logic [ADDR_W-1:0] R_L_addr,
  input  logic [ADDR_W-1:0] R_P_addr,
  output logic [DATA_W-1:0] R_R_data,
  output logic [DATA_W-1:0] R_L_data,
  output logic [DATA_W-1:0] R_P_data,
  output logic              R_valid,
  output logic              rot_ack,
  output logic [1:0]        hist_lvl,
  output logic [15:0]       frame_cnt,
  output logic              ovf
);
  localparam int PW = $clog2(NUM_BANKS);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_PEND = 1'b1;

  if (NUM_BANKS < 5) begin : g_bad_banks
    $error("bank_rotator_ctrl: NUM_BANKS must be >= 5");
  end
  if (DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("bank_rotator_ctrl: DEPTH exceeds 2**ADDR_W");
  end

  function automatic logic [PW-1:0] bank_at(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_BANKS) s = s - NUM_BANKS;
    return PW'(s);
  endfunction

  logic          state;
  logic [PW-1:0] wptr;
  logic [PW-1:0] wr_r, wr_l, rd_r, rd_l, rd_p;
  logic          any_we;
  logic          rotate;

  assign wr_r   = wptr;
  assign wr_l   = bank_at(wptr, 1);
  assign rd_r   = bank_at(wptr, NUM_BANKS - 2);
  assign rd_l   = bank_at(wptr, NUM_BANKS - 1);
  assign rd_p   = bank_at(wptr, NUM_BANKS - 3);
  assign any_we = WRE | WLE;

  // A frame boundary never splits a burst of writes: rotation waits for an idle cycle.
  assign rotate = ((state == ST_IDLE) && fsync && !any_we) ||
                  ((state == ST_PEND) && !any_we);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wptr      <= '0;
      rot_ack   <= 1'b0;
      hist_lvl  <= 2'd0;
      frame_cnt <= 16'd0;
      ovf       <= 1'b0;
    end else begin
      rot_ack <= rotate;
      if (rotate) begin
        wptr      <= bank_at(wptr, 2);
        frame_cnt <= frame_cnt + 16'd1;
        if (hist_lvl != 2'd2) hist_lvl <= hist_lvl + 2'd1;
      end
      case (state)
        ST_IDLE: if (fsync && any_we) state <= ST_PEND;
        ST_PEND: begin
          if (fsync) ovf <= 1'b1;
          if (!any_we) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic              bank_we    [NUM_BANKS];
  logic [ADDR_W-1:0] bank_waddr [NUM_BANKS];
  logic [DATA_W-1:0] bank_wdata [NUM_BANKS];
  logic [ADDR_W-1:0] bank_raddr [NUM_BANKS];
  logic [DATA_W-1:0] bank_rdata [NUM_BANKS];

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_we[b]    = 1'b0;
      bank_waddr[b] = '0;
      bank_wdata[b] = '0;
      bank_raddr[b] = '0;
      if (wr_r == PW'(b)) begin
        bank_we[b]    = WRE;
        bank_waddr[b] = W_R_addr;
        bank_wdata[b] = W_R_data;
      end
      if (wr_l == PW'(b)) begin
        bank_we[b]    = WLE;
        bank_waddr[b] = W_L_addr;
        bank_wdata[b] = W_L_data;
      end
      if (rd_r == PW'(b)) bank_raddr[b] = R_R_addr;
      if (rd_l == PW'(b)) bank_raddr[b] = R_L_addr;
      if (rd_p == PW'(b)) bank_raddr[b] = R_P_addr;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    bram_sd #(.DW(DATA_W), .AW(ADDR_W), .DEPTH(DEPTH)) u_bank (
      .clk   (clk),
      .we    (bank_we[g]),
      .waddr (bank_waddr[g]),
      .wdata (bank_wdata[g]),
      .re    (1'b1),
      .raddr (bank_raddr[g]),
      .rdata (bank_rdata[g])
    );
  end

  // Select travels with the BRAM read so a rotation on the issue cycle cannot redirect it.
  logic          rd_v1;
  logic [PW-1:0] sel_r, sel_l, sel_p;
  logic [DATA_W-1:0] mux_r, mux_l, mux_p;
  logic [DATA_W-1:0] hold_r, hold_l, hold_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v1 <= 1'b0;
      sel_r <= '0;
      sel_l <= '0;
      sel_p <= '0;
    end else begin
      rd_v1 <= R_en;
      if (R_en) begin
        sel_r <= rd_r;
        sel_l <= rd_l;
        sel_p <= rd_p;
      end
    end
  end

  assign mux_r = bank_rdata[sel_r];
  assign mux_l = bank_rdata[sel_l];
  assign mux_p = bank_rdata[sel_p];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_r <= '0;
      hold_l <= '0;
      hold_p <= '0;
    end else if (rd_v1) begin
      hold_r <= mux_r;
      hold_l <= mux_l;
      hold_p <= mux_p;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic rd_v2;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_v2 <= 1'b0;
      else     rd_v2 <= rd_v1;
    end
    assign R_valid  = rd_v2;
    assign R_R_data = hold_r;
    assign R_L_data = hold_l;
    assign R_P_data = hold_p;
  end else begin : g_out_comb
    assign R_valid  = rd_v1;
    assign R_R_data = rd_v1 ? mux_r : hold_r;
    assign R_L_data = rd_v1 ? mux_l : hold_l;
    assign R_P_data = rd_v1 ? mux_p : hold_p;
  end
endmodule

// File: tb/tb_bank_rotator_ctrl.sv
// Random frame traffic driven into two controllers (5 banks/no out reg, 7 banks/out reg)
// and checked against a frame-indexed history model.

module tb_bank_rotator_ctrl;
  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int NA  = 8;
  localparam int NFR = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fsync = 1'b0, WRE = 1'b0, WLE = 1'b0, R_en = 1'b0;
  logic [AW-1:0] W_R_addr = '0, W_L_addr = '0, R_R_addr = '0, R_L_addr = '0, R_P_addr = '0;
  logic [DW-1:0] W_R_data = '0, W_L_data = '0;

  logic [DW-1:0] r5_r, r5_l, r5_p, r7_r, r7_l, r7_p;
  logic          r5_v, r5_ack, r5_ovf, r7_v, r7_ack, r7_ovf;
  logic [1:0]    r5_hl, r7_hl;
  logic [15:0]   r5_fc, r7_fc;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bank_rotator_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16), .NUM_BANKS(5), .OUT_REG(0)) u5 (
    .clk(clk), .rst(rst), .fsync(fsync),
    .WRE(WRE), .W_R_addr(W_R_addr), .W_R_data(W_R_data),
    .WLE(WLE), .W_L_addr(W_L_addr), .W_L_data(W_L_data),
    .R_en(R_en), .R_R_addr(R_R_addr), .R_L_addr(R_L_addr), .R_P_addr(R_P_addr),
    .R_R_data(r5_r), .R_L_data(r5_l), .R_P_data(r5_p), .R_valid(r5_v),
    .rot_ack(r5_ack), .hist_lvl(r5_hl), .frame_cnt(r5_fc), .ovf(r5_ovf)
  );

  bank_rotator_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16), .NUM_BANKS(7), .OUT_REG(1)) u7 (
    .clk(clk), .rst(rst), .fsync(fsync),
    .WRE(WRE), .W_R_addr(W_R_addr), .W_R_data(W_R_data),
    .WLE(WLE), .W_L_addr(W_L_addr), .W_L_data(W_L_data),
    .R_en(R_en), .R_R_addr(R_R_addr), .R_L_addr(R_L_addr), .R_P_addr(R_P_addr),
    .R_R_data(r7_r), .R_L_data(r7_l), .R_P_data(r7_p), .R_valid(r7_v),
    .rot_ack(r7_ack), .hist_lvl(r7_hl), .frame_cnt(r7_fc), .ovf(r7_ovf)
  );

  typedef struct {
    int issue;
    bit hr; bit hl; bit hp;
    logic [DW-1:0] r; logic [DW-1:0] l; logic [DW-1:0] p;
  } rd_exp_t;
  typedef struct { int at; int cnt; } rot_exp_t;

  rd_exp_t  rd_q  [2][$];
  rot_exp_t rot_q [2][$];

  // Model memory: contents written per (frame, address), frame = rotations so far.
  logic [DW-1:0] r_mem [longint];
  logic [DW-1:0] l_mem [longint];
  int m_rot  = 0;
  bit m_pend = 1'b0;
  bit m_ovf  = 1'b0;
  bit rd_on  = 1'b1;
  bit mon_en = 1'b0;

  int checks = 0;
  int failures = 0;

  function automatic longint key(input int f, input int a);
    return longint'(f) * 256 + longint'(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit fs, input bit wr, input bit wl, input int a);
    rd_exp_t e;
    rot_exp_t ro;
    logic [DW-1:0] dr, dl;
    int rr, rl, rp;
    bit rot;
    dr = DW'($urandom_range(0, 65535));
    dl = DW'($urandom_range(0, 65535));
    rr = $urandom_range(0, NA - 1);
    rl = $urandom_range(0, NA - 1);
    rp = $urandom_range(0, NA - 1);
    fsync = fs; WRE = wr; WLE = wl;
    W_R_addr = AW'(a); W_L_addr = AW'(NA - 1 - a);
    W_R_data = dr; W_L_data = dl;
    R_en = rd_on && ($urandom_range(0, 2) != 0);
    R_R_addr = AW'(rr); R_L_addr = AW'(rl); R_P_addr = AW'(rp);
    if (R_en) begin
      e.issue = cyc;
      e.hr = r_mem.exists(key(m_rot - 1, rr));
      e.hl = l_mem.exists(key(m_rot - 1, rl));
      e.hp = l_mem.exists(key(m_rot - 2, rp));
      e.r = e.hr ? r_mem[key(m_rot - 1, rr)] : '0;
      e.l = e.hl ? l_mem[key(m_rot - 1, rl)] : '0;
      e.p = e.hp ? l_mem[key(m_rot - 2, rp)] : '0;
      rd_q[0].push_back(e);
      rd_q[1].push_back(e);
    end
    if (wr) r_mem[key(m_rot, a)] = dr;
    if (wl) l_mem[key(m_rot, NA - 1 - a)] = dl;
    rot = 1'b0;
    if (m_pend) begin
      if (fs) m_ovf = 1'b1;
      if (!wr && !wl) begin rot = 1'b1; m_pend = 1'b0; end
    end else if (fs) begin
      if (wr || wl) m_pend = 1'b1;
      else rot = 1'b1;
    end
    if (rot) begin
      m_rot++;
      ro.at = cyc + 1;
      ro.cnt = m_rot;
      rot_q[0].push_back(ro);
      rot_q[1].push_back(ro);
    end
    @(negedge clk);
  endtask

  task automatic check_dut(input int d, input logic rv, input logic [DW-1:0] dr,
                           input logic [DW-1:0] dl, input logic [DW-1:0] dp, input logic ra,
                           input logic [15:0] fc, input logic [1:0] hl);
    rd_exp_t e;
    rot_exp_t ro;
    int lat;
    lat = (d == 0) ? 1 : 2;
    if (rv) begin
      if (rd_q[d].size() == 0) chk($sformatf("dut%0d unexpected_valid", d), 64'd1, 64'd0);
      else begin
        e = rd_q[d].pop_front();
        chk($sformatf("dut%0d read_latency", d), 64'(cyc - e.issue), 64'(lat));
        if (e.hr) chk($sformatf("dut%0d R_R_data", d), 64'(dr), 64'(e.r));
        if (e.hl) chk($sformatf("dut%0d R_L_data", d), 64'(dl), 64'(e.l));
        if (e.hp) chk($sformatf("dut%0d R_P_data", d), 64'(dp), 64'(e.p));
      end
    end
    if (rd_q[d].size() > 0 && (cyc - rd_q[d][0].issue) > lat) begin
      e = rd_q[d].pop_front();
      chk($sformatf("dut%0d missing_valid", d), 64'd0, 64'd1);
    end
    if (ra) begin
      if (rot_q[d].size() == 0) chk($sformatf("dut%0d unexpected_rot_ack", d), 64'd1, 64'd0);
      else begin
        ro = rot_q[d].pop_front();
        chk($sformatf("dut%0d rot_ack_cycle", d), 64'(cyc), 64'(ro.at));
        chk($sformatf("dut%0d frame_cnt", d), 64'(fc), 64'(ro.cnt & 16'hffff));
        chk($sformatf("dut%0d hist_lvl", d), 64'(hl), 64'((ro.cnt > 2) ? 2 : ro.cnt));
      end
    end
    if (rot_q[d].size() > 0 && rot_q[d][0].at < cyc) begin
      ro = rot_q[d].pop_front();
      chk($sformatf("dut%0d missing_rot_ack", d), 64'd0, 64'd1);
    end
  endtask

  task automatic monitor();
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        check_dut(0, r5_v, r5_r, r5_l, r5_p, r5_ack, r5_fc, r5_hl);
        check_dut(1, r7_v, r7_r, r7_l, r7_p, r7_ack, r7_fc, r7_hl);
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " dut0 outputs"}, {r5_r, r5_l, r5_p, 7'(r5_v), r5_ack, r5_hl, r5_fc, r5_ovf}, 64'd0);
    chk({tag, " dut1 outputs"}, {r7_r, r7_l, r7_p, 7'(r7_v), r7_ack, r7_hl, r7_fc, r7_ovf}, 64'd0);
  endtask

  initial begin
    #3 rst = 1'b1;
    #1 chk_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_zero("after_reset");
    mon_en = 1'b1;
    fork monitor(); join_none

    for (int f = 0; f < NFR; f++) begin
      int j, j2;
      j  = (f == 10 || f == 3) ? 4 : $urandom_range(3, NA);
      j2 = (f == 10) ? 6 : -1;
      for (int a = 0; a < NA; a++) begin
        if (!m_pend) while ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b0, 0);
        step(a == j || a == j2, 1'b1, 1'b1, a);
      end
      if (j == NA) begin
        repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0);
      end else begin
        step(1'b0, 1'b0, 1'b0, 0);
      end
      repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 1'b0, 0);
    end

    rd_on = 1'b0;
    repeat (6) step(1'b0, 1'b0, 1'b0, 0);
    chk("dut0 final frame_cnt", 64'(r5_fc), 64'(m_rot));
    chk("dut1 final frame_cnt", 64'(r7_fc), 64'(NFR));
    chk("dut0 final hist_lvl", 64'(r5_hl), 64'd2);
    chk("dut1 final hist_lvl", 64'(r7_hl), 64'd2);
    chk("dut0 ovf", 64'(r5_ovf), 64'(m_ovf));
    chk("dut1 ovf", 64'(r7_ovf), 64'd1);
    chk("dut0 reads_drained", 64'(rd_q[0].size()), 64'd0);
    chk("dut1 reads_drained", 64'(rd_q[1].size()), 64'd0);
    chk("dut0 rots_drained", 64'(rot_q[0].size()), 64'd0);
    chk("dut1 rots_drained", 64'(rot_q[1].size()), 64'd0);

    // Reset while a rotation is pending: outputs clear without a clock, pending request is lost.
    step(1'b1, 1'b1, 1'b1, 0);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1 chk_zero("async_reset_pend");
    @(negedge clk);
    rst = 1'b0;
    fsync = 1'b0; WRE = 1'b0; WLE = 1'b0; R_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("dut0 pend_cleared", 64'(r5_fc), 64'd0);
    chk("dut1 pend_cleared", 64'(r7_fc), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
